// File: rtl/imem_loader_pkg.sv
// Shared definitions for the boot-time instruction-memory loader.
// INSTR_W is also the instruction-memory word width on the core side.
`timescale 1ns/1ps
package imem_loader_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int INSTR_W        = 32;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HDR   = 3'd1,
        S_LOAD  = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4,
        S_ERR   = 3'd5
    } state_e;

endpackage

// File: rtl/imem_loader_timeout.sv
// Idle-cycle counter. The expired flag is held once the count reaches TIMEOUT-1.
`timescale 1ns/1ps
module loader_timeout #(
    parameter int TIMEOUT = 1024
) (
    input  logic clk,
    input  logic clr_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != LIMIT)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_expired = (r_count == LIMIT);

endmodule

// File: rtl/imem_loader.sv
// Byte-stream program loader: assembles little-endian words, writes them to
// instruction memory and holds the core in reset until the program is complete.
`timescale 1ns/1ps
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W  = 4,
    parameter int DATA_W  = INSTR_W,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [DATA_W-1:0] wdata,
    output logic              cpu_rst_n,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   words_loaded
);

    localparam int          IDX_W      = $clog2(BYTES_PER_WORD);
    localparam logic [IDX_W-1:0] LAST_BYTE = IDX_W'(BYTES_PER_WORD - 1);
    localparam logic [8:0]  MAX_WORDS  = 9'(2 ** ADDR_W);

    state_e            r_state;
    logic [7:0]        r_n;
    logic [IDX_W-1:0]  r_byte_idx;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W:0]   r_words;
    logic [DATA_W-1:0] r_wdata;

    logic       w_xfer;
    logic       w_expired;
    logic       w_in_rx;
    logic [8:0] w_words_inc;

    assign w_in_rx     = (r_state == S_HDR) || (r_state == S_LOAD);
    assign w_xfer      = rx_valid && w_in_rx;
    assign w_words_inc = 9'(r_words) + 9'd1;

    // Counter runs only while waiting for bytes; WRITE leaves it untouched.
    loader_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk       (clk),
        .clr_n     (clr_n),
        .i_clear   (w_xfer || !(w_in_rx || (r_state == S_WRITE))),
        .i_enable  (w_in_rx && !w_xfer),
        .o_expired (w_expired)
    );

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_state    <= S_IDLE;
            r_n        <= '0;
            r_byte_idx <= '0;
            r_addr     <= '0;
            r_words    <= '0;
            r_wdata    <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        r_state    <= S_HDR;
                        r_addr     <= '0;
                        r_words    <= '0;
                        r_byte_idx <= '0;
                    end
                end
                S_HDR: begin
                    if (w_xfer) begin
                        if (rx_data == 8'd0) begin
                            r_state <= S_DONE;
                        end else if (9'(rx_data) > MAX_WORDS) begin
                            r_state <= S_ERR;
                        end else begin
                            r_n     <= rx_data;
                            r_state <= S_LOAD;
                        end
                    end else if (w_expired) begin
                        r_state <= S_ERR;
                    end
                end
                S_LOAD: begin
                    if (w_xfer) begin
                        // Shift right so the first byte ends up in the low lane.
                        r_wdata    <= {rx_data, r_wdata[DATA_W-1:8]};
                        r_byte_idx <= r_byte_idx + 1'b1;
                        if (r_byte_idx == LAST_BYTE) begin
                            r_state <= S_WRITE;
                        end
                    end else if (w_expired) begin
                        r_state <= S_ERR;
                    end
                end
                S_WRITE: begin
                    r_addr  <= r_addr + 1'b1;
                    r_words <= r_words + 1'b1;
                    r_state <= (w_words_inc == {1'b0, r_n}) ? S_DONE : S_LOAD;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign rx_ready     = w_in_rx;
    assign we           = (r_state == S_WRITE);
    assign waddr        = r_addr;
    assign wdata        = r_wdata;
    assign cpu_rst_n    = (r_state == S_DONE);
    assign busy         = w_in_rx || (r_state == S_WRITE);
    assign done         = (r_state == S_DONE);
    assign err          = (r_state == S_ERR);
    assign words_loaded = r_words;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: expected writes are queued as bytes are sent
// and matched against each we pulse by a negedge monitor.
`timescale 1ns/1ps
module tb_imem_loader;

    localparam int ADDR_W  = 4;
    localparam int TIMEOUT = 1024;

    logic              clk = 1'b0;
    logic              clr_n = 1'b0;
    logic              start = 1'b0;
    logic [7:0]        rx_data = 8'd0;
    logic              rx_valid = 1'b0;
    logic              rx_ready;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [31:0]       wdata;
    logic              cpu_rst_n;
    logic              busy;
    logic              done;
    logic              err;
    logic [ADDR_W:0]   words_loaded;

    int n_checks = 0;
    int n_errors = 0;
    int we_count = 0;
    logic [35:0] exp_q[$];

    imem_loader #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (32),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk          (clk),
        .clr_n        (clr_n),
        .start        (start),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .we           (we),
        .waddr        (waddr),
        .wdata        (wdata),
        .cpu_rst_n    (cpu_rst_n),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Every we pulse must match the oldest queued write.
    always @(negedge clk) begin
        if (we === 1'b1) begin
            logic [35:0] e;
            we_count++;
            if (exp_q.size() == 0) begin
                check("unexpected_we", 64'(waddr), 64'hFFFF);
            end else begin
                e = exp_q.pop_front();
                check("waddr", 64'(waddr), 64'(e[35:32]));
                check("wdata", 64'(wdata), 64'(e[31:0]));
            end
        end
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    // Called at a negedge; returns at the negedge following acceptance.
    task automatic send_byte(input logic [7:0] b);
        int n;
        rx_data  = b;
        rx_valid = 1'b1;
        n = 0;
        while (!rx_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("rx_accept", 64'(rx_ready), 64'd1);
        @(negedge clk);
    endtask

    task automatic send_word(input logic [ADDR_W-1:0] a, input logic [31:0] w, input int gap);
        exp_q.push_back({a, w});
        for (int i = 0; i < 4; i++) begin
            send_byte(w[8*i +: 8]);
            if (i == 3) check("we_latency", 64'(we), 64'd1);
            if (gap > 0) begin
                rx_valid = 1'b0;
                repeat (gap) @(negedge clk);
            end
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        int base;
        repeat (3) @(negedge clk);
        check("reset_outputs", 64'({rx_ready, we, waddr, wdata, cpu_rst_n, busy, done, err, words_loaded}), 64'd0);
        clr_n = 1'b1;
        @(negedge clk);
        check("idle_hold_core", 64'({cpu_rst_n, busy, rx_ready}), 64'd0);

        // Two-word program with rx_valid held
        pulse_start();
        check("hdr_busy", 64'({busy, cpu_rst_n}), 64'b10);
        send_byte(8'd2);
        send_word(4'd0, 32'h00A00513, 0);
        send_word(4'd1, 32'h00158593, 0);
        rx_valid = 1'b0;
        check("not_done_in_write", 64'(done), 64'd0);
        @(negedge clk);
        check("done_2", 64'({done, cpu_rst_n, busy, err}), 64'b1100);
        check("words_2", 64'(words_loaded), 64'd2);
        check("we_count_2", 64'(we_count), 64'd2);

        // Empty program
        base = we_count;
        pulse_start();
        check("restart_clears", 64'({done, cpu_rst_n, words_loaded}), 64'd0);
        send_byte(8'd0);
        rx_valid = 1'b0;
        check("done_n0", 64'({done, cpu_rst_n, err}), 64'b110);
        @(negedge clk);
        check("no_we_n0", 64'(we_count - base), 64'd0);

        // Oversized header, then recovery
        pulse_start();
        send_byte(8'd17);
        rx_valid = 1'b0;
        check("err_n17", 64'({err, cpu_rst_n, done, busy}), 64'b1000);
        check("no_we_n17", 64'(we_count - base), 64'd0);
        pulse_start();
        check("err_cleared", 64'(err), 64'd0);
        send_byte(8'd1);
        send_word(4'd0, 32'hDEADBEEF, 0);
        rx_valid = 1'b0;
        @(negedge clk);
        check("recover_done", 64'({done, cpu_rst_n, words_loaded}), {62'd0, 2'b11} << 5 | 64'd1);

        // Full fill, no address wrap
        base = we_count;
        pulse_start();
        send_byte(8'd16);
        for (int i = 0; i < 16; i++) begin
            send_word(ADDR_W'(i), 32'h1000_0000 + 32'(i) * 32'h0101_0101, 0);
        end
        rx_valid = 1'b0;
        @(negedge clk);
        check("full_done", 64'({done, cpu_rst_n}), 64'b11);
        check("full_words", 64'(words_loaded), 64'd16);
        check("full_we_count", 64'(we_count - base), 64'd16);

        // Timeout mid-word
        base = we_count;
        pulse_start();
        send_byte(8'd1);
        send_byte(8'hAA);
        send_byte(8'hBB);
        rx_valid = 1'b0;
        repeat (TIMEOUT - 1) @(negedge clk);
        check("timeout_edge", 64'({err, busy}), 64'b01);
        @(negedge clk);
        check("timeout_err", 64'({err, cpu_rst_n, busy}), 64'b100);
        check("timeout_no_we", 64'(we_count - base), 64'd0);
        pulse_start();
        send_byte(8'd1);
        send_word(4'd0, 32'hCAFE_0001, 0);
        rx_valid = 1'b0;
        @(negedge clk);
        check("after_timeout_done", 64'(done), 64'd1);

        // Gapped bytes, start during LOAD ignored, async reset mid-session
        pulse_start();
        send_byte(8'd3);
        rx_valid = 1'b0;
        repeat (2) @(negedge clk);
        send_word(4'd0, 32'h0403_0201, 2);
        send_byte(8'h55);
        rx_valid = 1'b0;
        pulse_start();
        check("start_in_load_ignored", 64'({busy, err, done, words_loaded}), 64'b100_00001);
        #2 clr_n = 1'b0;
        #1;
        check("async_reset_outputs", 64'({rx_ready, we, waddr, wdata, cpu_rst_n, busy, done, err, words_loaded}), 64'd0);
        @(negedge clk);
        clr_n = 1'b1;
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        @(negedge clk);
        pulse_start();
        send_byte(8'd1);
        send_word(4'd0, 32'h1234_5678, 1);
        @(negedge clk);
        check("reload_done", 64'({done, cpu_rst_n, words_loaded}), 64'b11_00001);
        check("final_queue", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time program loader directly upstream of the single-cycle core's instruction memory.
- Receives a byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words.
- Writes each word into instruction memory at incrementing addresses.
- Holds the core in reset until the whole program is written, then releases it.

Parameters:
- ADDR_W, 4, instruction-memory word-address width; capacity 2^ADDR_W words
- DATA_W, 32, instruction word width; fixed at 32, 4 bytes per word
- TIMEOUT, 1024, maximum idle cycles allowed between accepted bytes during HDR/LOAD before abort

Ports:
- clk  in  1  system clock, rising edge
- clr_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse that begins a load session
- rx_data  in  8  incoming byte
- rx_valid  in  1  rx_data is valid
- rx_ready  out  1  loader accepts a byte this cycle
- we  out  1  instruction-memory write enable, one cycle per word
- waddr  out  ADDR_W  instruction-memory word address
- wdata  out  32  assembled instruction word
- cpu_rst_n  out  1  active-low reset to core (PC and regfile clear)
- busy  out  1  session in progress (HDR/LOAD/WRITE)
- done  out  1  program fully loaded; level until next start or reset
- err  out  1  session aborted; level until next start or reset
- words_loaded  out  ADDR_W+1  count of words written this session

Behaviour:
- Reset (clr_n low, async): state IDLE, all outputs 0. This includes cpu_rst_n=0, so the core is held in reset. Byte index, word count and timeout counter are also cleared.
- Handshake: a byte transfers at a rising edge where rx_valid && rx_ready. rx_ready=1 only in HDR and LOAD; it is combinational from state.
- States:
  - IDLE: start -> HDR. Clear done, err, words_loaded, address.
  - HDR: accept one byte N, the word count.
    - N=0 -> DONE.
    - N>2^ADDR_W -> ERR.
    - Otherwise latch N -> LOAD.
  - LOAD: accept bytes into a shift register, LSB first (byte0 -> wdata[7:0] ... byte3 -> wdata[31:24]). The edge accepting byte3 -> WRITE.
  - WRITE: exactly one cycle with we=1, waddr=current address, wdata=assembled word. rx_ready=0.
    - At the end of WRITE: address+1 (wraps mod 2^ADDR_W; only reachable when N=2^ADDR_W), words_loaded+1.
    - Next state: DONE if words_loaded+1==N, else LOAD.
  - DONE: done=1, cpu_rst_n=1. start -> HDR, which re-asserts cpu_rst_n=0 in that same cycle.
  - ERR: err=1, cpu_rst_n=0. start -> HDR.
- Latency: we is high in the cycle immediately after the edge that accepted byte3. done and cpu_rst_n rise in the cycle after the final WRITE cycle.
- cpu_rst_n=0 in IDLE, HDR, LOAD, WRITE and ERR.
- busy=1 in HDR, LOAD and WRITE.
- Timeout:
  - Counter clears on every accepted byte and on entry to HDR. It increments every cycle in HDR/LOAD without a transfer.
  - Reaching TIMEOUT-1 -> ERR. A partial word is discarded and not written.
  - The counter is frozen in WRITE.
- start while busy is ignored.
- If start and rx_valid arrive together in IDLE, no byte is accepted (rx_ready=0 in IDLE).
- Reset mid-session: immediate return to IDLE and core held in reset. Memory contents already written are left as-is.
- we is never asserted outside WRITE.

Decomposition:
- Shared package holds:
  - State enum: IDLE, HDR, LOAD, WRITE, DONE, ERR.
  - BYTES_PER_WORD=4.
  - Instruction width constant 32, shared with the core's instruction memory.
- One sub-module, loader_timeout: a counter with clear, enable and expired flag, parameterised by TIMEOUT.

Test Plan:
- Reset then start, then N=2, then bytes 13,05,A0,00 and 93,85,15,00 with rx_valid held -> writes 0x00A00513 @0 and 0x00158593 @1. we is high once per word, in the cycle after the 4th byte. Then done=1, cpu_rst_n=1, words_loaded=2.
- N=0 -> DONE the cycle after the header: no we, cpu_rst_n=1.
- N=17 with ADDR_W=4 -> err=1, cpu_rst_n=0, no we. A subsequent start followed by N=1 and 4 bytes recovers to done.
- N=16 full fill -> 16 writes at waddr 0..15, words_loaded=16, done=1. Addresses do not wrap before done.
- N=1, 2 bytes sent, then rx_valid low for TIMEOUT cycles -> err=1, no we. The next session's first word goes to address 0.
- Gapped rx_valid (one byte per 3 cycles) with clr_n pulsed low after 5 bytes -> all outputs 0 asynchronously. A fresh start reloads correctly. start pulsed during LOAD has no effect.
